// File: rtl/bit_stuffer_param.sv
// ---------------------------------------------------------------------------
// bit_stuffer_param
//
// Flow-controlled bit stuffer for the USB transmit bit path. Sits between the
// serialiser and the NRZI encoder and inserts one ~TRIGGER_VAL bit after every
// run of RUN_LEN consecutive TRIGGER_VAL bits (USB default: a 0 after six 1s).
//
// Parameters:
//   RUN_LEN      run length that triggers a stuff bit (>= 2)
//   TRIGGER_VAL  bit value being counted; the stuffed bit is ~TRIGGER_VAL
//   CNT_W        width of stuff_count
//
// Ports:
//   clk          clock, rising edge
//   RST          synchronous active-high reset
//   in_bit       data bit from the upstream serialiser
//   in_valid     in_bit is valid
//   in_ready     block accepts in_bit this cycle
//   bypass       1 = pass bits through with no counting and no stuffing
//   clear        synchronous packet-boundary clear of run counter/stuff_count
//   out_bit      output bit to the NRZI encoder
//   out_valid    out_bit is valid
//   out_ready    downstream accepts out_bit
//   stuffed      current out_bit is an inserted stuff bit
//   stuff_count  stuff bits loaded since reset or clear (wraps)
// ---------------------------------------------------------------------------
module bit_stuffer_param #(
    parameter int   RUN_LEN     = 6,
    parameter logic TRIGGER_VAL = 1'b1,
    parameter int   CNT_W       = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             in_bit,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             bypass,
    input  logic             clear,
    output logic             out_bit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             stuffed,
    output logic [CNT_W-1:0] stuff_count
);

    localparam int               RUN_W   = $clog2(RUN_LEN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(RUN_LEN);

    typedef enum logic {
        PASS  = 1'b0,
        STUFF = 1'b1
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [RUN_W-1:0] run_cnt;
    logic [RUN_W-1:0] run_cnt_next;
    logic [RUN_W-1:0] run_base;
    logic [RUN_W-1:0] run_inc;
    logic             run_hit;
    logic             pending;
    logic             slot_free;
    logic             accept;
    logic             stuff_load;

    // The output slot can take a new bit when it is empty or being drained.
    // A pending stuff bit has priority over new input, which is why in_ready
    // drops for exactly the cycle in which the stuff bit loads.
    assign pending    = (state == STUFF);
    assign slot_free  = !out_valid || out_ready;
    assign in_ready   = !pending && slot_free;
    assign accept     = in_valid && in_ready;
    assign stuff_load = pending && slot_free;

    // Run counter and state update. A clear in the same cycle as an accept
    // means the accepted bit starts a fresh run, so the count is built from
    // zero rather than from the old run_cnt. Bypass pins the counter at zero
    // so normal operation always resumes with a clean run. An accept can only
    // occur in PASS, so run_hit never fires while a stuff bit is waiting.
    always_comb begin
        run_cnt_next = run_cnt;
        state_next   = state;
        run_base     = clear ? '0 : run_cnt;
        run_inc      = '0;
        run_hit      = 1'b0;

        if (clear) begin
            run_cnt_next = '0;
        end

        if (bypass) begin
            run_cnt_next = '0;
        end else if (accept) begin
            if (in_bit == TRIGGER_VAL) begin
                run_inc = run_base + RUN_W'(1);
            end
            run_hit      = (run_inc == RUN_MAX);
            run_cnt_next = run_hit ? '0 : run_inc;
        end

        case (state)
            PASS:    if (run_hit)    state_next = STUFF;
            STUFF:   if (stuff_load) state_next = PASS;
            default: state_next = PASS;
        endcase
    end

    // State and run counter registers. Reset discards any pending stuff bit.
    always_ff @(posedge clk) begin
        if (RST) begin
            state   <= PASS;
            run_cnt <= '0;
        end else begin
            state   <= state_next;
            run_cnt <= run_cnt_next;
        end
    end

    // Output register. Holds steady under backpressure; loads the stuff bit
    // first if one is pending, otherwise the accepted input bit, otherwise
    // empties once drained.
    always_ff @(posedge clk) begin
        if (RST) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            stuffed   <= 1'b0;
        end else if (slot_free) begin
            if (pending) begin
                out_bit   <= ~TRIGGER_VAL;
                out_valid <= 1'b1;
                stuffed   <= 1'b1;
            end else if (accept) begin
                out_bit   <= in_bit;
                out_valid <= 1'b1;
                stuffed   <= 1'b0;
            end else begin
                out_valid <= 1'b0;
                stuffed   <= 1'b0;
            end
        end
    end

    // Stuff event counter. A clear wins over a stuff load in the same cycle,
    // so the stuff bit still goes out but is not counted.
    always_ff @(posedge clk) begin
        if (RST || clear) begin
            stuff_count <= '0;
        end else if (stuff_load) begin
            stuff_count <= stuff_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_bit_stuffer_param.sv
// ---------------------------------------------------------------------------
// tb_bit_stuffer_param
//
// Directed bench for bit_stuffer_param. Instance A uses the USB defaults,
// instance B uses RUN_LEN = 3, TRIGGER_VAL = 0. Both share the stimulus
// signals; sel picks which instance is observed by the streaming task.
// ---------------------------------------------------------------------------
module tb_bit_stuffer_param;

    logic        clk = 1'b0;
    logic        RST;
    logic        in_bit;
    logic        in_valid;
    logic        bypass;
    logic        clear;
    logic        out_ready;

    logic        a_in_ready, a_out_bit, a_out_valid, a_stuffed;
    logic [15:0] a_count;
    logic        b_in_ready, b_out_bit, b_out_valid, b_stuffed;
    logic [15:0] b_count;

    logic        sel;
    logic        cur_in_ready, cur_out_bit, cur_out_valid, cur_stuffed;
    logic [15:0] cur_count;

    int          checks = 0;
    int          errors = 0;

    logic        stim_bits [64];
    logic        got_bits [$];
    logic        got_stuffed [$];
    int          ready_low;

    always #5 clk = ~clk;

    bit_stuffer_param dut_a (
        .clk        (clk),
        .RST        (RST),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (a_in_ready),
        .bypass     (bypass),
        .clear      (clear),
        .out_bit    (a_out_bit),
        .out_valid  (a_out_valid),
        .out_ready  (out_ready),
        .stuffed    (a_stuffed),
        .stuff_count(a_count)
    );

    bit_stuffer_param #(
        .RUN_LEN    (3),
        .TRIGGER_VAL(1'b0),
        .CNT_W      (16)
    ) dut_b (
        .clk        (clk),
        .RST        (RST),
        .in_bit     (in_bit),
        .in_valid   (in_valid),
        .in_ready   (b_in_ready),
        .bypass     (bypass),
        .clear      (clear),
        .out_bit    (b_out_bit),
        .out_valid  (b_out_valid),
        .out_ready  (out_ready),
        .stuffed    (b_stuffed),
        .stuff_count(b_count)
    );

    always_comb begin
        cur_in_ready  = sel ? b_in_ready  : a_in_ready;
        cur_out_bit   = sel ? b_out_bit   : a_out_bit;
        cur_out_valid = sel ? b_out_valid : a_out_valid;
        cur_stuffed   = sel ? b_stuffed   : a_stuffed;
        cur_count     = sel ? b_count     : a_count;
    end

    // Leaves the bench just after a rising edge with both instances reset.
    task automatic do_reset();
        RST       = 1'b1;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        bypass    = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        RST = 1'b0;
    endtask

    task automatic load_stim(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            stim_bits[i] = v[n-1-i];
        end
    endtask

    // Streams stim_bits[0..n-1] into the observed instance and collects the
    // output handshakes. Called and returns just after a rising edge.
    task automatic stream(input int n);
        int idx;
        int cyc;
        logic acc;
        idx = 0;
        cyc = 0;
        got_bits.delete();
        got_stuffed.delete();
        ready_low = 0;
        in_valid = (n > 0);
        in_bit   = stim_bits[0];
        while (cyc < 200) begin
            @(negedge clk);
            if (cur_out_valid && out_ready) begin
                got_bits.push_back(cur_out_bit);
                got_stuffed.push_back(cur_stuffed);
            end
            acc = in_valid && cur_in_ready;
            if (!cur_in_ready) ready_low++;
            if (idx >= n && !cur_out_valid) break;
            @(posedge clk); #1;
            if (acc) idx++;
            in_valid = (idx < n);
            in_bit   = (idx < n) ? stim_bits[idx] : 1'b0;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (cyc >= 200) begin
            errors++;
            $display("[TB] FAIL stream_timeout got=%0d cycles, required fewer than 200", cyc);
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pack_q(input logic q [$]);
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    // Reset values visible in the first cycle after reset.
    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_bit, a_stuffed} !== 3'b000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got=%b exp=000", {a_out_valid, a_out_bit, a_stuffed});
        end
        checks++;
        if (a_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_count got=%0d exp=0", a_count);
        end
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_in_ready got=%b exp=1", a_in_ready);
        end
        @(posedge clk); #1;
    endtask

    // Twelve 1s produce two stuff bits.
    task automatic test_twelve_ones();
        sel = 1'b0;
        do_reset();
        load_stim(64'hFFF, 12);
        stream(12);
        checks++;
        if (got_bits.size() != 14 || pack_q(got_bits) !== 32'b11111101111110) begin
            errors++;
            $display("[TB] FAIL t12_bits got=%b (n=%0d) exp=11111101111110", pack_q(got_bits), got_bits.size());
        end
        checks++;
        if (pack_q(got_stuffed) !== 32'b00000010000001) begin
            errors++;
            $display("[TB] FAIL t12_stuffed got=%b exp=00000010000001", pack_q(got_stuffed));
        end
        checks++;
        if (ready_low != 2) begin
            errors++;
            $display("[TB] FAIL t12_ready_low got=%0d exp=2", ready_low);
        end
        checks++;
        if (a_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL t12_count got=%0d exp=2", a_count);
        end
    endtask

    // Runs of five are not stuffed.
    task automatic test_no_stuff();
        sel = 1'b0;
        do_reset();
        load_stim(64'b111110111110, 12);
        stream(12);
        checks++;
        if (got_bits.size() != 12 || pack_q(got_bits) !== 32'b111110111110) begin
            errors++;
            $display("[TB] FAIL five_bits got=%b (n=%0d) exp=111110111110", pack_q(got_bits), got_bits.size());
        end
        checks++;
        if (pack_q(got_stuffed) !== 32'd0 || a_count !== 16'd0 || ready_low != 0) begin
            errors++;
            $display("[TB] FAIL five_nostuff got stuffed=%b count=%0d ready_low=%0d exp 0/0/0",
                     pack_q(got_stuffed), a_count, ready_low);
        end
    endtask

    // Stuff bit held under backpressure, then the next input follows it.
    task automatic test_backpressure();
        sel = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_bit, a_stuffed, a_in_ready} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL bp_sixth got v/b/s/rdy=%b exp=1100", {a_out_valid, a_out_bit, a_stuffed, a_in_ready});
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({a_out_valid, a_out_bit, a_stuffed, a_in_ready} !== 4'b1010) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d got v/b/s/rdy=%b exp=1010", i,
                         {a_out_valid, a_out_bit, a_stuffed, a_in_ready});
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_bit    = 1'b1;
        @(negedge clk);
        checks++;
        if (a_in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL bp_release_ready got=%b exp=1", a_in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_out_bit, a_stuffed} !== 3'b110 || a_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL bp_next got v/b/s=%b count=%0d exp=110 count=1",
                     {a_out_valid, a_out_bit, a_stuffed}, a_count);
        end
        @(posedge clk); #1;
    endtask

    // Bypass passes eight 1s untouched, then normal stuffing resumes from 0.
    task automatic test_bypass();
        sel = 1'b0;
        do_reset();
        bypass = 1'b1;
        load_stim(64'hFF, 8);
        stream(8);
        checks++;
        if (got_bits.size() != 8 || pack_q(got_bits) !== 32'hFF || pack_q(got_stuffed) !== 32'd0 ||
            a_count !== 16'd0 || ready_low != 0) begin
            errors++;
            $display("[TB] FAIL bypass got=%b (n=%0d) stuffed=%b count=%0d ready_low=%0d exp 11111111/0/0/0",
                     pack_q(got_bits), got_bits.size(), pack_q(got_stuffed), a_count, ready_low);
        end
        bypass = 1'b0;
        load_stim(64'h3F, 6);
        stream(6);
        checks++;
        if (got_bits.size() != 7 || pack_q(got_bits) !== 32'b1111110 || pack_q(got_stuffed) !== 32'b0000001) begin
            errors++;
            $display("[TB] FAIL bypass_resume got=%b stuffed=%b (n=%0d) exp=1111110 stuffed=0000001",
                     pack_q(got_bits), pack_q(got_stuffed), got_bits.size());
        end
        checks++;
        if (a_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL bypass_count got=%0d exp=1", a_count);
        end
    endtask

    // RUN_LEN = 3, TRIGGER_VAL = 0: a 1 after every three 0s.
    task automatic test_param_variant();
        sel = 1'b1;
        do_reset();
        load_stim(64'd0, 6);
        stream(6);
        checks++;
        if (got_bits.size() != 8 || pack_q(got_bits) !== 32'b00010001) begin
            errors++;
            $display("[TB] FAIL rl3_bits got=%b (n=%0d) exp=00010001", pack_q(got_bits), got_bits.size());
        end
        checks++;
        if (pack_q(got_stuffed) !== 32'b00010001 || b_count !== 16'd2) begin
            errors++;
            $display("[TB] FAIL rl3_stuff got stuffed=%b count=%0d exp=00010001 count=2",
                     pack_q(got_stuffed), b_count);
        end
        sel = 1'b0;
    endtask

    // Clear restarts the run with the bit accepted in the same cycle.
    task automatic test_clear();
        sel = 1'b0;
        do_reset();
        load_stim(64'h3FF, 10);
        stream(10);
        checks++;
        if (a_count !== 16'd1) begin
            errors++;
            $display("[TB] FAIL clr_pre_count got=%0d exp=1", a_count);
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        @(posedge clk); #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_count !== 16'd0 || {a_out_valid, a_out_bit, a_stuffed} !== 3'b110) begin
            errors++;
            $display("[TB] FAIL clr_cycle got count=%0d v/b/s=%b exp count=0 v/b/s=110",
                     a_count, {a_out_valid, a_out_bit, a_stuffed});
        end
        @(posedge clk); #1;
        load_stim(64'h1, 1);
        stream(1);
        checks++;
        if (got_bits.size() != 1 || pack_q(got_stuffed) !== 32'd0) begin
            errors++;
            $display("[TB] FAIL clr_no_stuff got n=%0d stuffed=%b exp n=1 stuffed=0",
                     got_bits.size(), pack_q(got_stuffed));
        end
        load_stim(64'hF, 4);
        stream(4);
        checks++;
        if (got_bits.size() != 5 || pack_q(got_bits) !== 32'b11110 || pack_q(got_stuffed) !== 32'b00001) begin
            errors++;
            $display("[TB] FAIL clr_rerun got=%b stuffed=%b (n=%0d) exp=11110 stuffed=00001",
                     pack_q(got_bits), pack_q(got_stuffed), got_bits.size());
        end
    endtask

    // Reset while a stuff bit is pending discards it.
    task automatic test_reset_pending();
        logic seen;
        sel = 1'b0;
        do_reset();
        in_valid = 1'b1;
        in_bit   = 1'b1;
        repeat (6) begin
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        RST      = 1'b1;
        @(posedge clk); #1;
        RST = 1'b0;
        @(negedge clk);
        checks++;
        if ({a_out_valid, a_stuffed, a_in_ready} !== 3'b001 || a_count !== 16'd0) begin
            errors++;
            $display("[TB] FAIL rst_pend got v/s/rdy=%b count=%0d exp=001 count=0",
                     {a_out_valid, a_stuffed, a_in_ready}, a_count);
        end
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (a_out_valid || a_stuffed) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_pend_emit got output activity=%b exp=0", seen);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        sel = 1'b0;
        test_reset();
        test_twelve_ones();
        test_no_stuff();
        test_backpressure();
        test_bypass();
        test_param_variant();
        test_clear();
        test_reset_pending();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
